parking_gate_arbiter: RTL and testbench

Round-robin scheduler that shares the single-event interface of `parking_management_system` among several entry/exit gate lanes. It serializes lane requests into one-cycle `car_entered`/`car_exited` pulses, checks vacancy flags and parked counts before committing, and drives a timed barrier-open signal per lane. It sits between the gate sensor lanes and `parking_management_system`.

---
 rtl/parking_pkg.sv | 19 +
 rtl/parking_barrier_timer.sv | 26 ++
 rtl/parking_gate_arbiter.sv | 151 +++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and widths for the parking gate arbiter and its barrier timers.
package parking_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StDeny   = 2'd2,
        StSettle = 2'd3
    } arb_state_e;

    localparam int unsigned COUNT_W = 10;
    localparam int unsigned STATS_W = 16;
    localparam int unsigned TIMER_W = 10;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/parking_barrier_timer.sv
// Per-lane barrier hold timer: a load (re)arms it, the barrier is open while it is non-zero.
module parking_barrier_timer
    import parking_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_count,
    output logic               o_open
);

    logic [TIMER_W-1:0] r_timer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (i_load) begin
            r_timer <= i_count;
        end else if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
        end
    end

    assign o_open = (r_timer != '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter serialising gate lane requests into single downstream events.
// Optional PARKING_ARB_STATS_EN adds saturating grant/deny counters.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int unsigned NUM_GATES   = 4,
    parameter int unsigned OPEN_CYCLES = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] gate_req,
    input  logic [NUM_GATES-1:0] gate_is_exit,
    input  logic [NUM_GATES-1:0] gate_is_uni,
    input  logic [COUNT_W-1:0]   uni_parked_car,
    input  logic [COUNT_W-1:0]   parked_car,
    input  logic                 uni_is_vacated_space,
    input  logic                 is_vacated_space,
    output logic                 car_entered,
    output logic                 car_exited,
    output logic                 is_uni_car_entered,
    output logic                 is_uni_car_exited,
    output logic [NUM_GATES-1:0] gate_grant,
    output logic [NUM_GATES-1:0] gate_deny,
    output logic [NUM_GATES-1:0] gate_open,
`ifdef PARKING_ARB_STATS_EN
    output logic [STATS_W-1:0]   grant_count,
    output logic [STATS_W-1:0]   deny_count,
`endif
    output logic                 busy
);

    localparam int unsigned PTR_W = $clog2(NUM_GATES);

    arb_state_e           r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [NUM_GATES-1:0] r_grant, r_deny;
    logic                 r_entered, r_exited, r_uni_entered, r_uni_exited;

    logic [PTR_W-1:0]     w_winner, w_next_ptr, w_idx;
    logic                 w_found, w_exit, w_uni, w_admit;
    logic [NUM_GATES-1:0] w_onehot, w_load;
    int unsigned          w_sum;

    // Wrapping search starting at the round-robin pointer; first hit wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = 0;
        w_idx    = '0;
        for (int unsigned i = 0; i < NUM_GATES; i++) begin
            w_sum = 32'(r_ptr) + i;
            if (w_sum >= NUM_GATES) begin
                w_sum = w_sum - NUM_GATES;
            end
            w_idx = PTR_W'(w_sum);
            if (!w_found && gate_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_exit     = gate_is_exit[w_winner];
    assign w_uni      = gate_is_uni[w_winner];
    assign w_admit    = w_exit ? (w_uni ? (uni_parked_car != '0) : (parked_car != '0))
                               : (w_uni ? uni_is_vacated_space : is_vacated_space);
    assign w_onehot   = NUM_GATES'(1) << w_winner;
    assign w_next_ptr = (w_winner == PTR_W'(NUM_GATES - 1)) ? '0 : w_winner + 1'b1;
    // Timer loads on the IDLE->ISSUE edge so the barrier opens with the grant pulse.
    assign w_load     = (r_state == StIdle && w_found && w_admit) ? w_onehot : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_deny        <= '0;
            r_entered     <= 1'b0;
            r_exited      <= 1'b0;
            r_uni_entered <= 1'b0;
            r_uni_exited  <= 1'b0;
        end else begin
            r_grant       <= '0;
            r_deny        <= '0;
            r_entered     <= 1'b0;
            r_exited      <= 1'b0;
            r_uni_entered <= 1'b0;
            r_uni_exited  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_ptr <= w_next_ptr;
                        if (w_admit) begin
                            r_state       <= StIssue;
                            r_grant       <= w_onehot;
                            r_entered     <= !w_exit;
                            r_exited      <= w_exit;
                            r_uni_entered <= !w_exit && w_uni;
                            r_uni_exited  <= w_exit && w_uni;
                        end else begin
                            r_state <= StDeny;
                            r_deny  <= w_onehot;
                        end
                    end
                end
                StIssue, StDeny: r_state <= StSettle;
                StSettle:        r_state <= StIdle;
                default:         r_state <= StIdle;
            endcase
        end
    end

`ifdef PARKING_ARB_STATS_EN
    logic [STATS_W-1:0] r_grant_count, r_deny_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_count <= '0;
            r_deny_count  <= '0;
        end else if (r_state == StIdle && w_found) begin
            if (w_admit) begin
                r_grant_count <= sat_inc(r_grant_count);
            end else begin
                r_deny_count  <= sat_inc(r_deny_count);
            end
        end
    end

    assign grant_count = r_grant_count;
    assign deny_count  = r_deny_count;
`endif

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_timer
        parking_barrier_timer u_timer (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_load[g]),
            .i_count (TIMER_W'(OPEN_CYCLES)),
            .o_open  (gate_open[g])
        );
    end

    assign gate_grant         = r_grant;
    assign gate_deny          = r_deny;
    assign car_entered        = r_entered;
    assign car_exited         = r_exited;
    assign is_uni_car_entered = r_uni_entered;
    assign is_uni_car_exited  = r_uni_exited;
    assign busy               = (r_state != StIdle);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed and randomized bench for parking_gate_arbiter against a cycle-level reference model.
module tb_parking_gate_arbiter;

    localparam int NG = 4;
    localparam int OC = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic [NG-1:0] gate_req, gate_is_exit, gate_is_uni;
    logic [9:0]    uni_parked_car, parked_car;
    logic          uni_is_vacated_space, is_vacated_space;
    logic          car_entered, car_exited, is_uni_car_entered, is_uni_car_exited;
    logic [NG-1:0] gate_grant, gate_deny, gate_open;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Reference model: round counter (0 = free to arbitrate), pointer, per-lane open time left.
    int            m_ptr;
    int            m_phase;
    int            m_timer [NG];
    int            last_lane;
    logic [NG-1:0] e_grant, e_deny;
    logic          e_ent, e_ext, e_uent, e_uext;

    parking_gate_arbiter #(.NUM_GATES(NG), .OPEN_CYCLES(OC)) dut (
        .clk                  (clk),
        .reset                (reset),
        .gate_req             (gate_req),
        .gate_is_exit         (gate_is_exit),
        .gate_is_uni          (gate_is_uni),
        .uni_parked_car       (uni_parked_car),
        .parked_car           (parked_car),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space),
        .car_entered          (car_entered),
        .car_exited           (car_exited),
        .is_uni_car_entered   (is_uni_car_entered),
        .is_uni_car_exited    (is_uni_car_exited),
        .gate_grant           (gate_grant),
        .gate_deny            (gate_deny),
        .gate_open            (gate_open),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_phase   = 0;
        last_lane = -1;
        for (int i = 0; i < NG; i++) m_timer[i] = 0;
        e_grant = '0; e_deny = '0;
        e_ent = 0; e_ext = 0; e_uent = 0; e_uext = 0;
    endtask

    // Predict what the next clock edge produces from the inputs currently applied.
    task automatic model_edge();
        bit ok;
        int l;
        last_lane = -1;
        e_grant = '0; e_deny = '0;
        e_ent = 0; e_ext = 0; e_uent = 0; e_uext = 0;
        for (int i = 0; i < NG; i++) if (m_timer[i] > 0) m_timer[i]--;
        if (m_phase == 0) begin
            for (int k = 0; k < NG; k++) begin
                l = (m_ptr + k) % NG;
                if (gate_req[l] && last_lane < 0) last_lane = l;
            end
            if (last_lane >= 0) begin
                l = last_lane;
                if (gate_is_exit[l])
                    ok = gate_is_uni[l] ? (uni_parked_car > 0) : (parked_car > 0);
                else
                    ok = gate_is_uni[l] ? uni_is_vacated_space : is_vacated_space;
                if (ok) begin
                    e_grant[l] = 1'b1;
                    m_timer[l] = OC;
                    if (gate_is_exit[l]) begin
                        e_ext  = 1;
                        e_uext = gate_is_uni[l];
                    end else begin
                        e_ent  = 1;
                        e_uent = gate_is_uni[l];
                    end
                end else begin
                    e_deny[l] = 1'b1;
                end
                m_ptr   = (l + 1) % NG;
                m_phase = 1;
            end
        end else begin
            m_phase = (m_phase + 1) % 3;
        end
    endtask

    task automatic check_all();
        logic [NG-1:0] e_open;
        for (int i = 0; i < NG; i++) e_open[i] = (m_timer[i] > 0);
        chk("grant", gate_grant, e_grant);
        chk("deny", gate_deny, e_deny);
        chk("car_entered", car_entered, e_ent);
        chk("car_exited", car_exited, e_ext);
        chk("uni_entered", is_uni_car_entered, e_uent);
        chk("uni_exited", is_uni_car_exited, e_uext);
        chk("gate_open", gate_open, e_open);
        chk("busy", busy, m_phase != 0);
    endtask

    // Advance one clock; the serviced lane drops its request right after grant/deny.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        if (last_lane >= 0) gate_req[last_lane] = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic req(input int lane, input logic ex, input logic uni);
        gate_is_exit[lane] = ex;
        gate_is_uni[lane]  = uni;
        gate_req[lane]     = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        gate_req = '0; gate_is_exit = '0; gate_is_uni = '0;
        uni_parked_car = '0; parked_car = '0;
        uni_is_vacated_space = 1'b0; is_vacated_space = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all();
        ticks(5);

        // Uni entry on lane 0 with space available; barrier held for OC cycles.
        uni_is_vacated_space = 1'b1;
        is_vacated_space     = 1'b1;
        req(0, 1'b0, 1'b1);
        tick();
        chk("t_uni_entry_grant", gate_grant, 4'b0001);
        chk("t_uni_entry_flag", is_uni_car_entered, 1'b1);
        ticks(60);

        // Lane 3 moves the pointer back to 0, then three simultaneous requests.
        req(3, 1'b0, 1'b0);
        ticks(3);
        req(0, 1'b0, 1'b0); req(1, 1'b0, 1'b0); req(2, 1'b0, 1'b0);
        tick();
        chk("t_rr_first", gate_grant, 4'b0001);
        ticks(2);
        tick();
        chk("t_rr_second", gate_grant, 4'b0010);
        ticks(2);
        tick();
        chk("t_rr_third", gate_grant, 4'b0100);
        ticks(2);
        req(0, 1'b0, 1'b0); req(3, 1'b0, 1'b0);
        tick();
        chk("t_rr_ptr3", gate_grant, 4'b1000);
        ticks(5);

        // Full lot: entry denied, turn consumed.
        is_vacated_space = 1'b0;
        req(1, 1'b0, 1'b0);
        tick();
        chk("t_full_deny", gate_deny, 4'b0010);
        chk("t_full_no_event", car_entered, 1'b0);
        ticks(2);
        is_vacated_space = 1'b1;
        req(1, 1'b0, 1'b0); req(2, 1'b0, 1'b0);
        tick();
        chk("t_deny_advances", gate_grant, 4'b0100);
        ticks(5);

        // Uni exit with no uni car parked, then with three.
        req(2, 1'b1, 1'b1);
        tick();
        chk("t_uni_exit_deny", gate_deny, 4'b0100);
        ticks(2);
        uni_parked_car = 10'd3;
        req(2, 1'b1, 1'b1);
        tick();
        chk("t_uni_exit_ok", car_exited, 1'b1);
        chk("t_uni_exit_flag", is_uni_car_exited, 1'b1);
        ticks(2);

        // Reset during ISSUE kills the pulse and barrier; arbitration restarts at lane 0.
        req(0, 1'b0, 1'b0); req(3, 1'b0, 1'b0);
        tick();
        chk("t_pre_reset_grant", gate_grant, 4'b1000);
        reset = 1'b1;
        #1;
        chk("t_rst_car_entered", car_entered, 1'b0);
        chk("t_rst_gate_open", gate_open, 4'b0000);
        chk("t_rst_grant", gate_grant, 4'b0000);
        chk("t_rst_busy", busy, 1'b0);
        model_reset();
        gate_req[3] = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("t_post_reset_lane0", gate_grant, 4'b0001);
        ticks(2);
        tick();
        chk("t_post_reset_lane3", gate_grant, 4'b1000);
        ticks(5);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            for (int l = 0; l < NG; l++) begin
                if (!gate_req[l] && $urandom_range(0, 3) == 0)
                    req(l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            uni_is_vacated_space = 1'($urandom_range(0, 1));
            is_vacated_space     = 1'($urandom_range(0, 1));
            uni_parked_car = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            parked_car     = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
